// File: rtl/mult8_seq_sched_if.sv
// Operand, sub-multiplier and result bundle for the sequential 8x8 scheduler.
// The master modport is the scheduler side; slave is the surrounding environment.
interface mult8_seq_sched_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        sub_valid;
  logic [3:0]  sub_a;
  logic [3:0]  sub_b;
  logic [7:0]  sub_r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r;

  modport master (
    input  in_valid, in_a, in_b, sub_r, out_ready,
    output in_ready, sub_valid, sub_a, sub_b, out_valid, out_r
  );

  modport slave (
    output in_valid, in_a, in_b, sub_r, out_ready,
    input  in_ready, sub_valid, sub_a, sub_b, out_valid, out_r
  );
endinterface

// File: rtl/mult8_seq_sched.sv
// 8x8 multiply by issuing nibble partial products to one shared 4x4 core, one per cycle.
// Latency popcount(mask)+1 edges; result held in DONE until out_ready, in_ready low in MUL.
module mult8_seq_sched #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  mult8_seq_sched_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  m_q, m_d;
  logic [1:0]  k_q, k_d;
  logic        out_valid_q, out_valid_d;

  logic        in_ready;
  logic        accept;
  logic        is_mul;
  logic [3:0]  mask_new;
  logic [3:0]  step_bit;
  logic [3:0]  shamt;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [15:0] pp_shifted;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign is_mul   = (state_q == MUL);

  // Step k pairs A nibble k[1] with B nibble k[0]; a step with a zero nibble contributes nothing.
  always_comb begin
    mask_new = 4'hF;
    if (SKIP_ZERO) begin
      mask_new[0] = (|bus.in_a[3:0]) & (|bus.in_b[3:0]);
      mask_new[1] = (|bus.in_a[3:0]) & (|bus.in_b[7:4]);
      mask_new[2] = (|bus.in_a[7:4]) & (|bus.in_b[3:0]);
      mask_new[3] = (|bus.in_a[7:4]) & (|bus.in_b[7:4]);
    end
  end

  assign nib_a      = k_q[1] ? a_q[7:4] : a_q[3:0];
  assign nib_b      = k_q[0] ? b_q[7:4] : b_q[3:0];
  assign step_bit   = 4'b0001 << k_q;
  assign shamt      = (k_q == 2'd0) ? 4'd0 : ((k_q == 2'd3) ? 4'd8 : 4'd4);
  assign pp_shifted = {8'd0, bus.sub_r} << shamt;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    m_d         = m_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;

    case (state_q)
      MUL: begin
        // Sum wraps modulo 2^16 so an approximate core can overshoot silently.
        acc_d = acc_q + pp_shifted;
        m_d   = m_q & ~step_bit;
        k_d   = lowest_bit(m_d);
        if (m_d == 4'd0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      a_d   = bus.in_a;
      b_d   = bus.in_b;
      acc_d = 16'd0;
      m_d   = mask_new;
      k_d   = lowest_bit(mask_new);
      if (mask_new == 4'd0) begin
        state_d     = DONE;
        out_valid_d = 1'b1;
      end else begin
        state_d     = MUL;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      acc_q       <= 16'd0;
      m_q         <= 4'd0;
      k_q         <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      m_q         <= m_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.sub_valid = is_mul;
  assign bus.sub_a     = is_mul ? nib_a : 4'd0;
  assign bus.sub_b     = is_mul ? nib_b : 4'd0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = acc_q;

endmodule

// File: tb/tb_mult8_seq_sched.sv
// Directed bench: one scheduler with all steps issued, one with zero-skipping, both on exact 4x4 models.
module tb_mult8_seq_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wrap = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mult8_seq_sched_if if_z ();
  mult8_seq_sched_if if_s ();

  // Exact 4x4 core; the all-steps instance can be switched to a saturated 0xFF core.
  assign if_z.sub_r = wrap ? 8'hFF : ({4'd0, if_z.sub_a} * {4'd0, if_z.sub_b});
  assign if_s.sub_r = {4'd0, if_s.sub_a} * {4'd0, if_s.sub_b};

  mult8_seq_sched #(.SKIP_ZERO(1'b0)) dut_z (.clk(clk), .rst(rst), .bus(if_z));
  mult8_seq_sched #(.SKIP_ZERO(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mul_z(input string tag, input logic [3:0] sa, input logic [3:0] sb);
    chk({tag, "_sub_valid"}, {15'd0, if_z.sub_valid}, 16'd1);
    chk({tag, "_sub_a"}, {12'd0, if_z.sub_a}, {12'd0, sa});
    chk({tag, "_sub_b"}, {12'd0, if_z.sub_b}, {12'd0, sb});
    chk({tag, "_in_ready"}, {15'd0, if_z.in_ready}, 16'd0);
    chk({tag, "_out_valid"}, {15'd0, if_z.out_valid}, 16'd0);
    tick();
  endtask

  initial begin
    if_z.in_valid = 1'b0; if_z.in_a = 8'd0; if_z.in_b = 8'd0; if_z.out_ready = 1'b0;
    if_s.in_valid = 1'b0; if_s.in_a = 8'd0; if_s.in_b = 8'd0; if_s.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_z_in_ready", {15'd0, if_z.in_ready}, 16'd1);
    chk("rst_z_out_valid", {15'd0, if_z.out_valid}, 16'd0);
    chk("rst_z_out_r", if_z.out_r, 16'h0000);
    chk("rst_z_sub_valid", {15'd0, if_z.sub_valid}, 16'd0);
    chk("rst_z_sub_a", {12'd0, if_z.sub_a}, 16'd0);
    chk("rst_z_sub_b", {12'd0, if_z.sub_b}, 16'd0);
    chk("rst_s_in_ready", {15'd0, if_s.in_ready}, 16'd1);
    chk("rst_s_out_valid", {15'd0, if_s.out_valid}, 16'd0);

    // All four steps for FF*FF, then a back-to-back accept from DONE
    if_z.out_ready = 1'b1;
    if_z.in_valid = 1'b1; if_z.in_a = 8'hFF; if_z.in_b = 8'hFF;
    tick();
    if_z.in_valid = 1'b0;
    mul_z("ff_k0", 4'hF, 4'hF);
    mul_z("ff_k1", 4'hF, 4'hF);
    mul_z("ff_k2", 4'hF, 4'hF);
    mul_z("ff_k3", 4'hF, 4'hF);
    chk("ff_out_valid", {15'd0, if_z.out_valid}, 16'd1);
    chk("ff_out_r", if_z.out_r, 16'hFE01);
    chk("ff_in_ready", {15'd0, if_z.in_ready}, 16'd1);
    if_z.in_valid = 1'b1; if_z.in_a = 8'h21; if_z.in_b = 8'h43;
    tick();
    if_z.in_valid = 1'b0;
    mul_z("b2b_k0", 4'h1, 4'h3);
    mul_z("b2b_k1", 4'h1, 4'h4);
    mul_z("b2b_k2", 4'h2, 4'h3);
    mul_z("b2b_k3", 4'h2, 4'h4);
    chk("b2b_out_valid", {15'd0, if_z.out_valid}, 16'd1);
    chk("b2b_out_r", if_z.out_r, 16'h08A3);
    tick();
    chk("b2b_idle_out_valid", {15'd0, if_z.out_valid}, 16'd0);

    // Zero-skip: single step, then an all-zero mask back to back
    if_s.out_ready = 1'b1;
    if_s.in_valid = 1'b1; if_s.in_a = 8'h0F; if_s.in_b = 8'h10;
    tick();
    if_s.in_valid = 1'b0;
    chk("skip1_sub_valid", {15'd0, if_s.sub_valid}, 16'd1);
    chk("skip1_sub_a", {12'd0, if_s.sub_a}, 16'h000F);
    chk("skip1_sub_b", {12'd0, if_s.sub_b}, 16'h0001);
    chk("skip1_out_valid_early", {15'd0, if_s.out_valid}, 16'd0);
    tick();
    chk("skip1_out_valid", {15'd0, if_s.out_valid}, 16'd1);
    chk("skip1_out_r", if_s.out_r, 16'h00F0);
    chk("skip1_sub_valid_done", {15'd0, if_s.sub_valid}, 16'd0);
    if_s.in_valid = 1'b1; if_s.in_a = 8'h00; if_s.in_b = 8'hA5;
    tick();
    if_s.in_valid = 1'b0;
    chk("skip0_sub_valid", {15'd0, if_s.sub_valid}, 16'd0);
    chk("skip0_out_valid", {15'd0, if_s.out_valid}, 16'd1);
    chk("skip0_out_r", if_s.out_r, 16'h0000);
    tick();
    chk("skip0_idle_out_valid", {15'd0, if_s.out_valid}, 16'd0);

    // Backpressure in DONE, released together with a new accept
    if_s.out_ready = 1'b0;
    if_s.in_valid = 1'b1; if_s.in_a = 8'h12; if_s.in_b = 8'h34;
    tick();
    if_s.in_valid = 1'b0;
    chk("bp_mul_in_ready", {15'd0, if_s.in_ready}, 16'd0);
    chk("bp_k0_sub_a", {12'd0, if_s.sub_a}, 16'h0002);
    chk("bp_k0_sub_b", {12'd0, if_s.sub_b}, 16'h0004);
    repeat (4) tick();
    if_s.in_valid = 1'b1; if_s.in_a = 8'h77; if_s.in_b = 8'h77;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_out_valid", {15'd0, if_s.out_valid}, 16'd1);
      chk("bp_hold_out_r", if_s.out_r, 16'h03A8);
      chk("bp_hold_in_ready", {15'd0, if_s.in_ready}, 16'd0);
      tick();
    end
    if_s.out_ready = 1'b1; if_s.in_a = 8'h02; if_s.in_b = 8'h03;
    #1;
    chk("bp_release_in_ready", {15'd0, if_s.in_ready}, 16'd1);
    chk("bp_release_out_r", if_s.out_r, 16'h03A8);
    tick();
    if_s.in_valid = 1'b0;
    chk("bp_next_sub_valid", {15'd0, if_s.sub_valid}, 16'd1);
    chk("bp_next_sub_a", {12'd0, if_s.sub_a}, 16'h0002);
    chk("bp_next_sub_b", {12'd0, if_s.sub_b}, 16'h0003);
    chk("bp_next_out_valid_early", {15'd0, if_s.out_valid}, 16'd0);
    tick();
    chk("bp_next_out_valid", {15'd0, if_s.out_valid}, 16'd1);
    chk("bp_next_out_r", if_s.out_r, 16'h0006);

    // Saturated core: 0xFF + 0xFF0 + 0xFF0 + 0xFF00 wraps to 0x1FDF; operands change mid-op
    wrap = 1'b1;
    if_z.in_valid = 1'b1; if_z.in_a = 8'hFF; if_z.in_b = 8'hFF;
    tick();
    if_z.in_valid = 1'b0; if_z.in_a = 8'h00; if_z.in_b = 8'h00;
    repeat (4) tick();
    chk("wrap_out_valid", {15'd0, if_z.out_valid}, 16'd1);
    chk("wrap_out_r", if_z.out_r, 16'h1FDF);
    wrap = 1'b0;
    tick();

    // Reset during the second MUL cycle, then a fresh operation
    if_z.in_valid = 1'b1; if_z.in_a = 8'hFF; if_z.in_b = 8'hFF;
    tick();
    if_z.in_valid = 1'b0;
    tick();
    chk("rstmid_pre_sub_valid", {15'd0, if_z.sub_valid}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_in_ready", {15'd0, if_z.in_ready}, 16'd1);
    chk("rstmid_out_valid", {15'd0, if_z.out_valid}, 16'd0);
    chk("rstmid_sub_valid", {15'd0, if_z.sub_valid}, 16'd0);
    chk("rstmid_sub_a", {12'd0, if_z.sub_a}, 16'd0);
    chk("rstmid_out_r", if_z.out_r, 16'h0000);
    if_z.in_valid = 1'b1; if_z.in_a = 8'h03; if_z.in_b = 8'h05;
    tick();
    if_z.in_valid = 1'b0;
    repeat (3) tick();
    chk("rstmid_new_out_valid_early", {15'd0, if_z.out_valid}, 16'd0);
    tick();
    chk("rstmid_new_out_valid", {15'd0, if_z.out_valid}, 16'd1);
    chk("rstmid_new_out_r", if_z.out_r, 16'h000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult8_seq_sched.md
# mult8_seq_sched

Sequential scheduler that computes an 8x8 product by time-multiplexing one shared 4x4 sub-multiplier core, such as the LM_1 approximate unit, over up to four cycles. It splits each operand into nibbles, issues the four nibble partial products one per cycle, and shift-accumulates the returned 8-bit results into a 16-bit product. It is the area-reduced, multi-cycle alternative to the four-core parallel 8x8 multiplier. It sits between a valid/ready operand source and a valid/ready result sink. The sub-multiplier is external and combinational, so the core (exact or approximate) is chosen at integration.

## Interface
- SKIP_ZERO, default 1: when 1, partial products with a zero nibble operand are skipped, giving variable latency. When 0, all four steps are always issued.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  scheduler can accept operands
- in_a  in  8  multiplicand A
- in_b  in  8  multiplier B
- sub_valid  out  1  sub_a/sub_b carry a live partial-product request this cycle
- sub_a  out  4  nibble to sub-multiplier
- sub_b  out  4  nibble to sub-multiplier
- sub_r  in  8  sub-multiplier result (combinational, same cycle)
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_r  out  16  accumulated product

## Operation
- States: IDLE, MUL, DONE.
- Steps, in order:
  - k=0: A[3:0]*B[3:0], shift 0
  - k=1: A[3:0]*B[7:4], shift 4
  - k=2: A[7:4]*B[3:0], shift 4
  - k=3: A[7:4]*B[7:4], shift 8
- Accept happens when in_valid & in_ready:
  - Latch A and B, clear the accumulator.
  - Build step mask m[3:0]. With SKIP_ZERO=0, m=4'b1111. With SKIP_ZERO=1, m[k]=1 only if both nibbles of step k are nonzero.
  - If m==0, go to DONE. Otherwise go to MUL with the current step set to the lowest set bit of m.
- Each MUL cycle:
  - sub_valid=1, and sub_a/sub_b carry the nibbles of the current step.
  - At the clock edge: acc <= acc + (sub_r << shift), clear m[k], advance to the next set bit.
  - Go to DONE when no set bits remain.
- Arithmetic: 16-bit unsigned, modulo 2^16. With an exact core, overflow cannot occur. With an approximate core, the sum may exceed 0xFFFF and must wrap silently. There is no saturation.
- DONE: out_valid=1 and out_r=acc, both held stable until out_ready.
  - out_ready=1 with no new accept: go to IDLE.
  - out_ready=1 with a simultaneous accept: take the accept path directly, as in back-to-back operation.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is low throughout MUL.
- Outside MUL: sub_valid=0, sub_a=0, sub_b=0.
- rst in any state, including mid-MUL or DONE:
  - Abandon the operation and go to IDLE.
  - Clear acc, m, and the latched operands.
  - The result is never presented.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_r=0, sub_valid=0, sub_a=0, sub_b=0.
- Latency is N+1 edges from the accept edge to the first cycle out_valid=1, where N = popcount(m):
  - SKIP_ZERO=0: always 5 cycles. out_valid rises at the 5th edge after accept (4 MUL cycles, then DONE).
  - SKIP_ZERO=1, m==0: out_valid is high in the cycle immediately after the accept edge.
- sub_r is sampled on the same edge that ends its MUL cycle. The sub-multiplier must settle within one cycle.
- Throughput without backpressure, with a back-to-back accept in DONE: one result per N+1 cycles.
- out_r and out_valid are registered. in_ready and the sub_* outputs are combinational from state, with out_ready feeding in_ready.
- in_a and in_b are ignored except on accept edges. Changing them mid-operation has no effect.

## Test plan
Use an exact 4x4 sub-multiplier model unless noted.
- SKIP_ZERO=0, A=0xFF, B=0xFF, out_ready=1 -> sub_valid high 4 consecutive cycles with steps k=0..3. out_r=0xFE01 with out_valid at the 5th edge after accept.
- SKIP_ZERO=1, A=0x0F, B=0x10 -> exactly one MUL cycle (sub_a=0xF, sub_b=0x1). out_r=0x00F0, out_valid 2 edges after accept.
- SKIP_ZERO=1, A=0x00, B=0xA5 -> sub_valid never high. out_r=0x0000, out_valid 1 edge after accept.
- Backpressure, A=0x12, B=0x34: hold out_ready=0 for 3 cycles in DONE -> out_r=0x03A8 stable, out_valid=1, in_ready=0. Raise out_ready with in_valid=1, A=0x02, B=0x03 -> accept on the same edge. Next result is 0x0006.
- Wrap, SKIP_ZERO=0: model returns sub_r=0xFF always, A=B=0xFF -> out_r=0x1FDF (73695 mod 2^16).
- Reset mid-MUL: assert rst during the 2nd MUL cycle of A=B=0xFF -> next cycle IDLE, in_ready=1, out_valid=0, sub_valid=0. A new accept of A=0x03, B=0x05 yields 0x000F.
